// File: rtl/obi_mem_arbiter_if.sv
// Bus bundle for the two-host / one-device OBI arbiter: both host ports, the device port and status.
// The slave modport is the arbiter's view; master is the view of whatever drives hosts and device.
interface obi_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    h0_req, h0_gnt, h0_rvalid, h0_we, h0_err;
    logic [ADDR_WIDTH-1:0]   h0_addr;
    logic [DATA_WIDTH/8-1:0] h0_be;
    logic [DATA_WIDTH-1:0]   h0_wdata, h0_rdata;

    logic                    h1_req, h1_gnt, h1_rvalid, h1_we, h1_err;
    logic [ADDR_WIDTH-1:0]   h1_addr;
    logic [DATA_WIDTH/8-1:0] h1_be;
    logic [DATA_WIDTH-1:0]   h1_wdata, h1_rdata;

    logic                    dev_req, dev_gnt, dev_rvalid, dev_we, dev_err;
    logic [ADDR_WIDTH-1:0]   dev_addr;
    logic [DATA_WIDTH/8-1:0] dev_be;
    logic [DATA_WIDTH-1:0]   dev_wdata, dev_rdata;

    logic [3:0]              outstanding;
    logic                    protocol_err;

    modport slave (
        input  h0_req, h0_addr, h0_we, h0_be, h0_wdata,
        output h0_gnt, h0_rvalid, h0_rdata, h0_err,
        input  h1_req, h1_addr, h1_we, h1_be, h1_wdata,
        output h1_gnt, h1_rvalid, h1_rdata, h1_err,
        output dev_req, dev_addr, dev_we, dev_be, dev_wdata,
        input  dev_gnt, dev_rvalid, dev_rdata, dev_err,
        output outstanding, protocol_err
    );

    modport master (
        output h0_req, h0_addr, h0_we, h0_be, h0_wdata,
        input  h0_gnt, h0_rvalid, h0_rdata, h0_err,
        output h1_req, h1_addr, h1_we, h1_be, h1_wdata,
        input  h1_gnt, h1_rvalid, h1_rdata, h1_err,
        input  dev_req, dev_addr, dev_we, dev_be, dev_wdata,
        output dev_gnt, dev_rvalid, dev_rdata, dev_err,
        input  outstanding, protocol_err
    );
endinterface

// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI device between two hosts; the address phase is locked
// until granted and responses are steered back in order through a FIFO of host IDs.
module obi_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input logic              clk_i,
    input logic              rst_ni,
    obi_mem_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {IDLE, LOCKED_H0, LOCKED_H1} state_t;

    state_t                  state_q, state_d;
    logic                    last_q, last_d;
    logic                    perr_q, perr_d;
    logic [3:0]              count_q;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic                    id_q [MAX_OUTSTANDING];
    logic                    sel, req, grant, pop, full, head;
    logic [ADDR_WIDTH-1:0]   addr_mux;
    logic [DATA_WIDTH/8-1:0] be_mux;
    logic [DATA_WIDTH-1:0]   wdata_mux;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (count_q == 4'(MAX_OUTSTANDING));
    assign head = id_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        perr_d  = perr_q;
        sel     = 1'b0;
        req     = 1'b0;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!full && (bus.h0_req || bus.h1_req)) begin
                    sel = (bus.h0_req && bus.h1_req) ? ~last_q : bus.h1_req;
                    req = 1'b1;
                    if (bus.dev_gnt) begin
                        grant  = 1'b1;
                        last_d = sel;
                    end else begin
                        state_d = sel ? LOCKED_H1 : LOCKED_H0;
                    end
                end
            end
            LOCKED_H0, LOCKED_H1: begin
                // Selection frozen while locked; full cannot occur here since nothing was pushed.
                sel = (state_q == LOCKED_H1);
                if (sel ? bus.h1_req : bus.h0_req) begin
                    req = 1'b1;
                    if (bus.dev_gnt) begin
                        grant   = 1'b1;
                        last_d  = sel;
                        state_d = IDLE;
                    end
                end else begin
                    perr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pop = bus.dev_rvalid && (count_q != 4'd0);
        if (bus.dev_rvalid && (count_q == 4'd0)) perr_d = 1'b1;

        if (!rst_ni) begin
            req   = 1'b0;
            grant = 1'b0;
            pop   = 1'b0;
        end
    end

    assign addr_mux  = sel ? bus.h1_addr  : bus.h0_addr;
    assign be_mux    = sel ? bus.h1_be    : bus.h0_be;
    assign wdata_mux = sel ? bus.h1_wdata : bus.h0_wdata;

    assign bus.dev_req   = req;
    assign bus.dev_addr  = addr_mux;
    assign bus.dev_we    = sel ? bus.h1_we : bus.h0_we;
    assign bus.dev_be    = be_mux;
    assign bus.dev_wdata = wdata_mux;

    assign bus.h0_gnt    = grant && !sel;
    assign bus.h1_gnt    = grant && sel;
    assign bus.h0_rvalid = pop && !head;
    assign bus.h1_rvalid = pop && head;
    assign bus.h0_err    = pop && !head && bus.dev_err;
    assign bus.h1_err    = pop && head && bus.dev_err;
    assign bus.h0_rdata  = bus.dev_rdata;
    assign bus.h1_rdata  = bus.dev_rdata;

    assign bus.outstanding  = count_q;
    assign bus.protocol_err = perr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            perr_q   <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            perr_q  <= perr_d;
            if (grant) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (grant && !pop)      count_q <= count_q + 4'd1;
            else if (pop && !grant) count_q <= count_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant) id_q[wr_ptr_q] <= sel;
    end
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter: one vector per clock cycle from a table, then
// hand-written sequences for the address-lock and request-drop cases.
module tb_obi_mem_arbiter;
    localparam logic        H0_WE    = 1'b0;
    localparam logic [3:0]  H0_BE    = 4'hF;
    localparam logic [31:0] H0_WDATA = 32'h0000_1111;
    localparam logic        H1_WE    = 1'b1;
    localparam logic [3:0]  H1_BE    = 4'h3;
    localparam logic [31:0] H1_WDATA = 32'h2222_0000;

    typedef struct {
        bit          rst_n, r0, r1, gnt, rv, er;
        logic [31:0] a0, a1, rd;
        bit          e_g0, e_g1, e_v0, e_v1, e_e0, e_e1, e_req, e_sel, e_perr;
        logic [31:0] e_addr;
        logic [3:0]  e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    obi_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    obi_mem_arbiter #(.MAX_OUTSTANDING(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic [31:0] rst, r0, r1, a0, a1, g, rv, rd, er,
                               eg0, eg1, ev0, ev1, ee0, ee1, ereq, esel, eaddr, ecnt, eperr);
        vec_t t;
        t.rst_n = rst[0]; t.r0 = r0[0]; t.r1 = r1[0]; t.a0 = a0; t.a1 = a1;
        t.gnt = g[0]; t.rv = rv[0]; t.rd = rd; t.er = er[0];
        t.e_g0 = eg0[0]; t.e_g1 = eg1[0]; t.e_v0 = ev0[0]; t.e_v1 = ev1[0];
        t.e_e0 = ee0[0]; t.e_e1 = ee1[0]; t.e_req = ereq[0]; t.e_sel = esel[0];
        t.e_addr = eaddr; t.e_cnt = ecnt[3:0]; t.e_perr = eperr[0];
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic r0, input logic r1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic g, input logic rv, input logic [31:0] rd, input logic er);
        @(negedge clk);
        rst_n = rst;
        bus.h0_req = r0; bus.h1_req = r1; bus.h0_addr = a0; bus.h1_addr = a1;
        bus.dev_gnt = g; bus.dev_rvalid = rv; bus.dev_rdata = rd; bus.dev_err = er;
        #1;
    endtask

    initial begin
        bus.h0_we = H0_WE; bus.h0_be = H0_BE; bus.h0_wdata = H0_WDATA;
        bus.h1_we = H1_WE; bus.h1_be = H1_BE; bus.h1_wdata = H1_WDATA;
        rst_n = 1'b0;
        bus.h0_req = 1'b0; bus.h1_req = 1'b0; bus.h0_addr = '0; bus.h1_addr = '0;
        bus.dev_gnt = 1'b0; bus.dev_rvalid = 1'b0; bus.dev_rdata = '0; bus.dev_err = 1'b0;
        repeat (2) @(posedge clk);

        //            rst r0 r1 a0      a1       g rv rd           er  g0 g1 v0 v1 e0 e1 rq sl addr     cnt perr
        // reset: device activity is ignored
        vecs.push_back(v(0, 0, 0, 0,      0,       1, 1, 0,           0,  0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0));
        // h0 alone, immediate grant, response next cycle
        vecs.push_back(v(1, 1, 0, 'h80,   0,       1, 0, 0,           0,  1, 0, 0, 0, 0, 0, 1, 0, 'h80,    0, 0));
        vecs.push_back(v(1, 0, 0, 0,      0,       0, 1, 'hDEADBEEF,  0,  0, 0, 1, 0, 0, 0, 0, 0, 0,       1, 0));
        // re-reset, then both hosts continuously: grants and rvalids alternate from h0
        vecs.push_back(v(0, 0, 0, 0,      0,       0, 0, 0,           0,  0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0));
        vecs.push_back(v(1, 1, 1, 'h100,  'h200,   1, 0, 0,           0,  1, 0, 0, 0, 0, 0, 1, 0, 'h100,   0, 0));
        vecs.push_back(v(1, 1, 1, 'h104,  'h204,   1, 1, 'h1111,      0,  0, 1, 1, 0, 0, 0, 1, 1, 'h204,   1, 0));
        vecs.push_back(v(1, 1, 1, 'h108,  'h208,   1, 1, 'h2222,      0,  1, 0, 0, 1, 0, 0, 1, 0, 'h108,   1, 0));
        vecs.push_back(v(1, 1, 1, 'h10C,  'h20C,   1, 1, 'h3333,      0,  0, 1, 1, 0, 0, 0, 1, 1, 'h20C,   1, 0));
        vecs.push_back(v(1, 0, 0, 0,      0,       0, 1, 'h4444,      0,  0, 0, 0, 1, 0, 0, 0, 0, 0,       1, 0));
        // fill to MAX_OUTSTANDING, requests gated, one response frees one slot
        vecs.push_back(v(1, 1, 0, 'h300,  0,       1, 0, 0,           0,  1, 0, 0, 0, 0, 0, 1, 0, 'h300,   0, 0));
        vecs.push_back(v(1, 0, 1, 0,      'h400,   1, 0, 0,           0,  0, 1, 0, 0, 0, 0, 1, 1, 'h400,   1, 0));
        vecs.push_back(v(1, 1, 1, 'h304,  'h404,   1, 0, 0,           0,  0, 0, 0, 0, 0, 0, 0, 0, 0,       2, 0));
        vecs.push_back(v(1, 1, 1, 'h304,  'h404,   1, 1, 'h5555,      1,  0, 0, 1, 0, 1, 0, 0, 0, 0,       2, 0));
        vecs.push_back(v(1, 1, 1, 'h304,  'h404,   1, 0, 0,           0,  1, 0, 0, 0, 0, 0, 1, 0, 'h304,   1, 0));
        vecs.push_back(v(1, 1, 1, 'h308,  'h404,   1, 1, 'h6666,      0,  0, 0, 0, 1, 0, 0, 0, 0, 0,       2, 0));
        vecs.push_back(v(1, 0, 0, 0,      0,       0, 1, 'h7777,      1,  0, 0, 1, 0, 1, 0, 0, 0, 0,       1, 0));
        // rvalid with empty FIFO: sticky protocol error, no host response
        vecs.push_back(v(1, 0, 0, 0,      0,       0, 1, 'h8888,      1,  0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0));
        vecs.push_back(v(1, 0, 0, 0,      0,       0, 0, 0,           0,  0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 1));
        vecs.push_back(v(1, 1, 0, 'h500,  0,       1, 0, 0,           0,  1, 0, 0, 0, 0, 0, 1, 0, 'h500,   0, 1));
        vecs.push_back(v(1, 0, 0, 0,      0,       0, 1, 'h9999,      0,  0, 0, 1, 0, 0, 0, 0, 0, 0,       1, 1));
        // two outstanding, then reset with a late device rvalid
        vecs.push_back(v(1, 1, 1, 'h600,  'h700,   1, 0, 0,           0,  0, 1, 0, 0, 0, 0, 1, 1, 'h700,   0, 1));
        vecs.push_back(v(1, 1, 1, 'h600,  'h704,   1, 0, 0,           0,  1, 0, 0, 0, 0, 0, 1, 0, 'h600,   1, 1));
        vecs.push_back(v(0, 0, 0, 0,      0,       0, 1, 'hAAAA,      0,  0, 0, 0, 0, 0, 0, 0, 0, 0,       2, 1));
        vecs.push_back(v(0, 0, 0, 0,      0,       0, 1, 'hBBBB,      0,  0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0));
        vecs.push_back(v(1, 0, 0, 0,      0,       0, 0, 0,           0,  0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0));

        foreach (vecs[i]) begin
            vec_t t;
            t = vecs[i];
            drive(t.rst_n, t.r0, t.r1, t.a0, t.a1, t.gnt, t.rv, t.rd, t.er);
            chk($sformatf("row%0d h0_gnt", i),       32'(bus.h0_gnt),       32'(t.e_g0));
            chk($sformatf("row%0d h1_gnt", i),       32'(bus.h1_gnt),       32'(t.e_g1));
            chk($sformatf("row%0d h0_rvalid", i),    32'(bus.h0_rvalid),    32'(t.e_v0));
            chk($sformatf("row%0d h1_rvalid", i),    32'(bus.h1_rvalid),    32'(t.e_v1));
            chk($sformatf("row%0d h0_err", i),       32'(bus.h0_err),       32'(t.e_e0));
            chk($sformatf("row%0d h1_err", i),       32'(bus.h1_err),       32'(t.e_e1));
            chk($sformatf("row%0d dev_req", i),      32'(bus.dev_req),      32'(t.e_req));
            chk($sformatf("row%0d outstanding", i),  32'(bus.outstanding),  32'(t.e_cnt));
            chk($sformatf("row%0d protocol_err", i), 32'(bus.protocol_err), 32'(t.e_perr));
            if (t.e_req) begin
                chk($sformatf("row%0d dev_addr", i),  bus.dev_addr, t.e_addr);
                chk($sformatf("row%0d dev_we", i),    32'(bus.dev_we), t.e_sel ? 32'(H1_WE) : 32'(H0_WE));
                chk($sformatf("row%0d dev_be", i),    32'(bus.dev_be), t.e_sel ? 32'(H1_BE) : 32'(H0_BE));
                chk($sformatf("row%0d dev_wdata", i), bus.dev_wdata,   t.e_sel ? H1_WDATA : H0_WDATA);
            end
            if (t.e_v0) chk($sformatf("row%0d h0_rdata", i), bus.h0_rdata, t.rd);
            if (t.e_v1) chk($sformatf("row%0d h1_rdata", i), bus.h1_rdata, t.rd);
        end

        // h1 locked at 0x10000 for three stalled cycles while h0 joins in cycle 2
        drive(1'b1, 1'b0, 1'b1, 32'h80, 32'h10000, 1'b0, 1'b0, '0, 1'b0);
        chk("lock c1 dev_req",  32'(bus.dev_req), 1);
        chk("lock c1 dev_addr", bus.dev_addr, 32'h10000);
        chk("lock c1 h1_gnt",   32'(bus.h1_gnt), 0);
        for (int c = 2; c <= 3; c++) begin
            drive(1'b1, 1'b1, 1'b1, 32'h80, 32'h10000, 1'b0, 1'b0, '0, 1'b0);
            chk($sformatf("lock c%0d dev_addr", c), bus.dev_addr, 32'h10000);
            chk($sformatf("lock c%0d h0_gnt", c),   32'(bus.h0_gnt), 0);
            chk($sformatf("lock c%0d h1_gnt", c),   32'(bus.h1_gnt), 0);
        end
        drive(1'b1, 1'b1, 1'b1, 32'h80, 32'h10000, 1'b1, 1'b0, '0, 1'b0);
        chk("lock c4 h1_gnt",    32'(bus.h1_gnt), 1);
        chk("lock c4 h0_gnt",    32'(bus.h0_gnt), 0);
        chk("lock c4 dev_addr",  bus.dev_addr, 32'h10000);
        chk("lock c4 dev_wdata", bus.dev_wdata, H1_WDATA);
        drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h10000, 1'b1, 1'b0, '0, 1'b0);
        chk("lock c5 h0_gnt",      32'(bus.h0_gnt), 1);
        chk("lock c5 dev_addr",    bus.dev_addr, 32'h80);
        chk("lock c5 outstanding", 32'(bus.outstanding), 1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h00C0FFEE, 1'b0);
        chk("lock r1 h1_rvalid", 32'(bus.h1_rvalid), 1);
        chk("lock r1 h0_rvalid", 32'(bus.h0_rvalid), 0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h00BADF00, 1'b0);
        chk("lock r2 h0_rvalid", 32'(bus.h0_rvalid), 1);
        chk("lock r2 h0_rdata",  bus.h0_rdata, 32'h00BADF00);

        // h0 withdraws its request while locked: no grant to anyone, sticky error
        drive(1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 1'b0, 1'b0, '0, 1'b0);
        chk("drop c1 dev_req",     32'(bus.dev_req), 1);
        chk("drop c1 outstanding", 32'(bus.outstanding), 0);
        drive(1'b1, 1'b0, 1'b1, 32'h84, 32'h20000, 1'b1, 1'b0, '0, 1'b0);
        chk("drop c2 dev_req",      32'(bus.dev_req), 0);
        chk("drop c2 h1_gnt",       32'(bus.h1_gnt), 0);
        chk("drop c2 protocol_err", 32'(bus.protocol_err), 0);
        drive(1'b1, 1'b0, 1'b1, 32'h84, 32'h20000, 1'b1, 1'b0, '0, 1'b0);
        chk("drop c3 h1_gnt",       32'(bus.h1_gnt), 1);
        chk("drop c3 dev_addr",     bus.dev_addr, 32'h20000);
        chk("drop c3 protocol_err", 32'(bus.protocol_err), 1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b0);
        chk("drop c4 outstanding", 32'(bus.outstanding), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
